// File: rtl/portin_fifo.sv
// Serial router input port: decodes a frame_n/valid_n/di lane into {addr, payload}
// packets and queues complete packets in a show-ahead circular buffer.
module portin_fifo #(
  parameter int ADDR_W    = 4,
  parameter int PAYLOAD_W = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_n,
  input  logic                   valid_n,
  input  logic                   di,
  output logic                   out_vld,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [PAYLOAD_W-1:0]   out_payload,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [1:0]             fsm_state
);
  localparam int MAXW  = (ADDR_W > PAYLOAD_W) ? ADDR_W : PAYLOAD_W;
  localparam int CW    = $clog2(MAXW);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PKT_W = ADDR_W + PAYLOAD_W;
  localparam logic [CW-1:0]    A_LAST   = CW'(ADDR_W - 1);
  localparam logic [CW-1:0]    P_LAST   = CW'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 resync;
  logic [ADDR_W-1:0]    addr_sr, addr_shift;
  logic [PAYLOAD_W-1:0] pay_sr, pay_shift;
  logic                 err_evt, commit_evt;
  logic                 pend;
  logic [ADDR_W-1:0]    pend_addr;
  logic [PAYLOAD_W-1:0] pend_payload;

  logic [PKT_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 full, do_pop, do_push, drop_evt;

  assign fsm_state = state;

  // Bits arrive LSB first, so shift right and insert at the MSB.
  always_comb begin
    addr_shift = addr_sr >> 1;
    addr_shift[ADDR_W-1] = di;
    pay_shift = pay_sr >> 1;
    pay_shift[PAYLOAD_W-1] = di;
  end

  always_comb begin
    err_evt    = 1'b0;
    commit_evt = 1'b0;
    case (state)
      IDLE: err_evt = !resync && !valid_n;
      ADDR: err_evt = frame_n || !valid_n;
      DATA: begin
        if (!valid_n) begin
          if (!frame_n) begin
            err_evt = (cnt == P_LAST);
          end else begin
            commit_evt = (cnt == P_LAST);
            err_evt    = (cnt != P_LAST);
          end
        end else if (frame_n) begin
          err_evt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // resync keeps a frame already in flight at reset release from being decoded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      resync       <= 1'b1;
      addr_sr      <= '0;
      pay_sr       <= '0;
      pend         <= 1'b0;
      pend_addr    <= '0;
      pend_payload <= '0;
      err_cnt      <= '0;
    end else begin
      pend <= commit_evt;
      if (commit_evt) begin
        pend_addr    <= addr_sr;
        pend_payload <= pay_shift;
      end
      if (err_evt && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (resync) begin
            if (frame_n) resync <= 1'b0;
          end else if (!frame_n && valid_n) begin
            addr_sr <= addr_shift;
            if (ADDR_W == 1) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              state <= ADDR;
              cnt   <= CW'(1);
            end
          end else if (!frame_n && !valid_n) begin
            state <= DROP;
          end
        end
        ADDR: begin
          if (!frame_n && valid_n) begin
            addr_sr <= addr_shift;
            if (cnt == A_LAST) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (!frame_n) begin
            state <= DROP;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!valid_n) begin
            pay_sr <= pay_shift;
            if (!frame_n) begin
              if (cnt == P_LAST) state <= DROP;
              else cnt <= cnt + 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (frame_n) begin
            state <= IDLE;
          end
        end
        default: if (frame_n) state <= IDLE;
      endcase
    end
  end

  // A pop on the push edge frees the slot, so a full buffer still accepts the push.
  assign full     = (level == LVL_FULL);
  assign do_pop   = pop && (level != '0);
  assign do_push  = pend && (!full || do_pop);
  assign drop_evt = pend && full && !do_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {pend_addr, pend_payload};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop_evt && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign out_vld                 = (level != '0);
  assign {out_addr, out_payload} = mem[rd_ptr];
endmodule

// File: tb/tb_portin_fifo.sv
// Directed plus randomized bench for portin_fifo against a packet-level queue model.
module tb_portin_fifo;
  localparam int ADDR_W    = 4;
  localparam int PAYLOAD_W = 32;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 8;
  localparam int PKT_W     = ADDR_W + PAYLOAD_W;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   frame_n = 1'b1;
  logic                   valid_n = 1'b1;
  logic                   di = 1'b0;
  logic                   pop = 1'b0;
  logic                   out_vld;
  logic [ADDR_W-1:0]      out_addr;
  logic [PAYLOAD_W-1:0]   out_payload;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       err_cnt;
  logic [CNT_W-1:0]       drop_cnt;
  logic [1:0]             fsm_state;

  portin_fifo #(.ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .di(di),
    .out_vld(out_vld), .out_addr(out_addr), .out_payload(out_payload), .pop(pop),
    .level(level), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [PKT_W-1:0] exp_q[$];
  int exp_err  = 0;
  int exp_drop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic d);
    @(negedge clock);
    frame_n = f;
    valid_n = v;
    di      = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0);
  endtask

  // npads pad cycles are inserted just before payload bit pad_at.
  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [63:0] p,
                            input int npay, input int npads, input int pad_at);
    for (int i = 0; i < ADDR_W; i++) drive(1'b0, 1'b1, a[i]);
    for (int i = 0; i < npay; i++) begin
      if (i == pad_at) repeat (npads) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (i == npay - 1) drive(1'b1, 1'b0, p[i]);
      else drive(1'b0, 1'b0, p[i]);
    end
  endtask

  task automatic model_frame(input logic [ADDR_W-1:0] a, input logic [63:0] p, input int npay);
    if (npay == PAYLOAD_W) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({a, p[PAYLOAD_W-1:0]});
      else if (exp_drop < CMAX) exp_drop++;
    end else if (exp_err < CMAX) begin
      exp_err++;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, "_level"}, 64'(level), 64'(exp_q.size()));
  endtask

  task automatic pop_check(input string tag);
    logic [PKT_W-1:0] head;
    head = exp_q.pop_front();
    check({tag, "_vld"}, 64'(out_vld), 64'd1);
    check({tag, "_addr"}, 64'(out_addr), 64'(head[PKT_W-1:PAYLOAD_W]));
    check({tag, "_payload"}, 64'(out_payload), 64'(head[PAYLOAD_W-1:0]));
    @(negedge clock);
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
    check({tag, "_lvl_after"}, 64'(level), 64'(exp_q.size()));
  endtask

  task automatic send_good(input logic [ADDR_W-1:0] a, input logic [63:0] p);
    send_frame(a, p, PAYLOAD_W, 0, 0);
    model_frame(a, p, PAYLOAD_W);
  endtask

  // Valid/ready: the lane has no backpressure; a packet is consumed when pop is
  // high at a rising edge while out_vld is high.
  initial begin
    logic [ADDR_W-1:0] a;
    logic [63:0]       p;
    logic [PKT_W-1:0]  head;
    int kind, npay, npops;

    repeat (3) @(negedge clock);
    #1;
    check("rst_vld", 64'(out_vld), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_payload", 64'(out_payload), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);

    // Basic packet and push latency.
    send_frame(4'h5, 64'hDEADBEEF, PAYLOAD_W, 0, 0);
    model_frame(4'h5, 64'hDEADBEEF, PAYLOAD_W);
    @(posedge clock);
    #1 check("lat_edge_e", 64'(out_vld), 64'd0);
    drive(1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #1 check("lat_edge_e1", 64'(out_vld), 64'd1);
    check_counts("basic");
    pop_check("basic_pop");
    check("basic_empty", 64'(out_vld), 64'd0);

    // Pads mid-payload.
    send_frame(4'h5, 64'hDEADBEEF, PAYLOAD_W, 2, 13);
    model_frame(4'h5, 64'hDEADBEEF, PAYLOAD_W);
    idle(2);
    check_counts("pads");
    pop_check("pads_pop");

    // Short then overlong, then a good frame.
    p = {$urandom, $urandom};
    send_frame(4'h3, p, PAYLOAD_W - 1, 0, 0);
    model_frame(4'h3, p, PAYLOAD_W - 1);
    idle(2);
    check_counts("short");
    send_frame(4'h3, p, PAYLOAD_W + 1, 0, 0);
    model_frame(4'h3, p, PAYLOAD_W + 1);
    idle(2);
    check_counts("long");
    a = 4'($urandom);
    p = {$urandom, $urandom};
    send_good(a, p);
    idle(2);
    check_counts("after_err");
    pop_check("after_err_pop");

    // Five back-to-back frames into a four-entry buffer.
    for (int i = 1; i <= 5; i++) send_good(4'(i), {$urandom, $urandom});
    idle(2);
    check_counts("full");
    for (int i = 1; i <= 4; i++) pop_check("full_pop");

    // Pop on the push edge of a fifth frame while full.
    for (int i = 0; i < 4; i++) send_good(4'($urandom), {$urandom, $urandom});
    idle(2);
    check_counts("prefill");
    a = 4'hA;
    p = {$urandom, $urandom};
    send_frame(a, p, PAYLOAD_W, 0, 0);
    head = exp_q.pop_front();
    check("pp_head_addr", 64'(out_addr), 64'(head[PKT_W-1:PAYLOAD_W]));
    check("pp_head_payload", 64'(out_payload), 64'(head[PAYLOAD_W-1:0]));
    @(negedge clock);
    frame_n = 1'b1;
    valid_n = 1'b1;
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
    model_frame(a, p, PAYLOAD_W);
    idle(1);
    check_counts("popped_push");
    for (int i = 0; i < 4; i++) pop_check("pp_drain");

    // Randomized mix of good, short and overlong frames with random pops.
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      a = 4'($urandom);
      p = {$urandom, $urandom};
      if (kind <= 1) npay = PAYLOAD_W;
      else if (kind == 2) npay = $urandom_range(1, PAYLOAD_W - 1);
      else npay = $urandom_range(PAYLOAD_W + 1, PAYLOAD_W + 8);
      send_frame(a, p, npay, $urandom_range(0, 3), $urandom_range(0, npay - 1));
      model_frame(a, p, npay);
      idle(2);
      check_counts("rand");
      npops = $urandom_range(0, 2);
      while (npops > 0 && exp_q.size() > 0) begin
        pop_check("rand_pop");
        npops--;
      end
    end

    // Counter saturation via address aborts.
    for (int i = 0; i < CMAX + 5; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      drive(1'b1, 1'b1, 1'b0);
      if (exp_err < CMAX) exp_err++;
    end
    idle(1);
    check("err_saturate", 64'(err_cnt), 64'(CMAX));

    // Reset during payload bit 10, with packets possibly still queued.
    send_good(4'h7, {$urandom, $urandom});
    idle(2);
    a = 4'($urandom);
    p = {$urandom, $urandom};
    for (int i = 0; i < ADDR_W; i++) drive(1'b0, 1'b1, a[i]);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, p[i]);
    @(negedge clock);
    valid_n = 1'b0;
    di = p[10];
    reset = 1'b1;
    #1;
    check("mid_rst_vld", 64'(out_vld), 64'd0);
    check("mid_rst_addr", 64'(out_addr), 64'd0);
    check("mid_rst_payload", 64'(out_payload), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_err", 64'(err_cnt), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    exp_err = 0;
    exp_drop = 0;
    idle(2);
    reset = 1'b0;
    idle(2);
    a = 4'($urandom);
    p = {$urandom, $urandom};
    send_good(a, p);
    idle(2);
    check_counts("post_rst");
    pop_check("post_rst_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
